input_packet_arbiter: RTL and testbench

- Sits directly downstream of the input-port cluster in each leaf interface, on the clk_bft domain.
- Takes the NUM_IN_PORTS packet buses produced by the input ports and picks one packet per cycle with a round-robin arbiter.
- Registers the winner into a single output stage and drives it toward the BFT upstream link, with backpressure.
- Returns a one-cycle consume pulse to the granted input port so that port can advance to its next packet.

---
 rtl/input_packet_arbiter.sv | 103 ++++++++++
 tb/tb_input_packet_arbiter.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/input_packet_arbiter.sv
// input_packet_arbiter: round-robin pick of one input packet per cycle into a backpressured output register.
// Optional INPUT_PACKET_ARBITER_STATS_EN adds a saturating stall_count output.
module input_packet_arbiter #(
    parameter int PACKET_BITS   = 97,
    parameter int NUM_IN_PORTS  = 7,
    parameter int NUM_PORT_BITS = 4,
    parameter int PORT_BASE     = 2
) (
    input  logic                                 clk_bft,
    input  logic                                 reset,
    input  logic [PACKET_BITS*NUM_IN_PORTS-1:0]  packet_from_input_ports,
    output logic [NUM_IN_PORTS-1:0]              ack_to_input_ports,
    output logic [PACKET_BITS-1:0]               stream_out,
    input  logic                                 stream_out_ready,
    output logic [NUM_PORT_BITS-1:0]             grant_port
`ifdef INPUT_PACKET_ARBITER_STATS_EN
    ,
    output logic [15:0]                          stall_count
`endif
);
    localparam int MSB = PACKET_BITS - 1;

    logic [PACKET_BITS-1:0]   stream_q, stream_d;
    logic [NUM_PORT_BITS-1:0] grant_q, grant_d;
    logic [NUM_IN_PORTS-1:0]  ack_q, ack_d, last_q, last_d, req, elig;
    logic [3:0]               rr_q, rr_d, win;
    logic                     free, found;
    int                       idx;

    // Requests are packet valid bits; the previous winner sits out one cycle
    always_comb begin
        for (int i = 0; i < NUM_IN_PORTS; i++) req[i] = packet_from_input_ports[PACKET_BITS*i + MSB];
        elig = req & ~last_q;
        free = !stream_q[MSB] || stream_out_ready;
    end

    // First eligible index after rr_q, wrapping at NUM_IN_PORTS-1
    always_comb begin
        found = 1'b0;
        win   = rr_q;
        idx   = 0;
        for (int k = 1; k <= NUM_IN_PORTS; k++) begin
            idx = int'(rr_q) + k;
            idx = idx >= NUM_IN_PORTS ? idx - NUM_IN_PORTS : idx;
            if (!found && elig[idx]) begin
                found = 1'b1;
                win   = 4'(idx);
            end
        end
    end

    // Capture the winner when the output stage is free, otherwise hold or empty it
    always_comb begin
        stream_d = stream_q;
        grant_d  = grant_q;
        rr_d     = rr_q;
        ack_d    = '0;
        last_d   = '0;
        if (free && found) begin
            stream_d = packet_from_input_ports[PACKET_BITS*int'(win) +: PACKET_BITS];
            grant_d  = NUM_PORT_BITS'(PORT_BASE + int'(win));
            rr_d     = win;
            ack_d    = NUM_IN_PORTS'(1) << win;
            last_d   = ack_d;
        end else if (free) begin
            stream_d[MSB] = 1'b0;
            grant_d       = '0;
        end
    end

    // State registers; reset drops any held packet without acking it
    always_ff @(posedge clk_bft or negedge reset) begin
        if (!reset) begin
            stream_q <= '0;
            grant_q  <= '0;
            ack_q    <= '0;
            last_q   <= '0;
            rr_q     <= 4'(NUM_IN_PORTS - 1);
        end else begin
            stream_q <= stream_d;
            grant_q  <= grant_d;
            ack_q    <= ack_d;
            last_q   <= last_d;
            rr_q     <= rr_d;
        end
    end

    assign stream_out         = stream_q;
    assign grant_port         = grant_q;
    assign ack_to_input_ports = ack_q;

`ifdef INPUT_PACKET_ARBITER_STATS_EN
    logic [15:0] stall_q;

    // Saturating count of cycles where a valid output is held by backpressure
    always_ff @(posedge clk_bft or negedge reset) begin
        if (!reset) stall_q <= '0;
        else stall_q <= (stream_q[MSB] && !stream_out_ready && stall_q != 16'hFFFF) ? stall_q + 16'd1 : stall_q;
    end

    assign stall_count = stall_q;
`endif
endmodule

// File: tb/tb_input_packet_arbiter.sv
// tb_input_packet_arbiter: directed and randomized checks of input_packet_arbiter against a behavioural model.
module tb_input_packet_arbiter;
    localparam int PB = 97;
    localparam int N = 7;
    localparam int PBASE = 2;

    logic              clk_bft = 1'b0;
    logic              reset = 1'b0;
    logic              stream_out_ready = 1'b0;
    logic [PB*N-1:0]   packet_from_input_ports;
    logic [N-1:0]      ack_to_input_ports;
    logic [PB-1:0]     stream_out;
    logic [3:0]        grant_port;
`ifdef INPUT_PACKET_ARBITER_STATS_EN
    logic [15:0]       stall_count;
    logic [15:0]       m_stall;
`endif

    logic [PB-1:0] pkt [N];
    logic [PB-1:0] m_out, saved;
    logic [3:0]    m_grant;
    logic [N-1:0]  m_ack, pending;
    int            m_rr, m_last, mode, tests, fails;
    bit            prev_nz;
    int            seq [3] = '{2, 5, 7};

    input_packet_arbiter dut (
        .clk_bft(clk_bft),
        .reset(reset),
        .packet_from_input_ports(packet_from_input_ports),
        .ack_to_input_ports(ack_to_input_ports),
        .stream_out(stream_out),
        .stream_out_ready(stream_out_ready),
`ifdef INPUT_PACKET_ARBITER_STATS_EN
        .stall_count(stall_count),
`endif
        .grant_port(grant_port)
    );

    always #5 clk_bft = ~clk_bft;

    always_comb
        for (int i = 0; i < N; i++) packet_from_input_ports[PB*i +: PB] = pkt[i];

    function automatic logic [PB-1:0] newpkt(bit v);
        return {v, 32'($urandom), 32'($urandom), 32'($urandom)};
    endfunction

    task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_out = '0; m_grant = '0; m_ack = '0; m_rr = N - 1; m_last = -1; pending = '0;
`ifdef INPUT_PACKET_ARBITER_STATS_EN
        m_stall = '0;
`endif
    endtask

    // Model: one packet per free cycle, round robin after the last winner, previous winner skipped
    task automatic step();
        int w;
        bit fr;
        fr = !m_out[PB-1] || stream_out_ready;
`ifdef INPUT_PACKET_ARBITER_STATS_EN
        if (m_out[PB-1] && !stream_out_ready && m_stall != 16'hFFFF) m_stall++;
`endif
        w = -1;
        if (fr)
            for (int k = 1; k <= N; k++) begin
                int i;
                i = (m_rr + k) % N;
                if (w < 0 && pkt[i][PB-1] && i != m_last) w = i;
            end
        if (w >= 0) begin
            m_out = pkt[w]; m_grant = 4'(PBASE + w); m_ack = '0; m_ack[w] = 1'b1; m_rr = w; m_last = w;
        end else begin
            m_ack = '0; m_last = -1;
            if (fr) begin m_out[PB-1] = 1'b0; m_grant = '0; end
        end
        @(posedge clk_bft);
        #1;
        for (int i = 0; i < N; i++)
            if (pending[i] && mode != 0)
                pkt[i] = newpkt(mode == 1 ? 1'b1 : mode == 2 ? 1'b0 : 1'($urandom));
        chk("stream_out", 128'(stream_out), 128'(m_out));
        chk("grant_port", 128'(grant_port), 128'(m_grant));
        chk("ack", 128'(ack_to_input_ports), 128'(m_ack));
`ifdef INPUT_PACKET_ARBITER_STATS_EN
        chk("stall_count", 128'(stall_count), 128'(m_stall));
`endif
        pending = m_ack;
    endtask

    task automatic drain();
        mode = 0;
        stream_out_ready = 1'b1;
        for (int i = 0; i < N; i++) pkt[i] = '0;
        repeat (3) step();
    endtask

    initial begin
        tests = 0; fails = 0; mode = 0;
        for (int i = 0; i < N; i++) pkt[i] = '0;
        model_reset();
        repeat (2) @(posedge clk_bft);
        #1;
        chk("rst_stream", 128'(stream_out), 0);
        chk("rst_grant", 128'(grant_port), 0);
        chk("rst_ack", 128'(ack_to_input_ports), 0);
        @(negedge clk_bft);
        reset = 1'b1;
        stream_out_ready = 1'b1;
        repeat (20) begin
            step();
            chk("idle_ack", 128'(ack_to_input_ports), 0);
        end

        pkt[0] = newpkt(1); pkt[3] = newpkt(1); pkt[5] = newpkt(1);
        for (int k = 0; k < 6; k++) begin
            step();
            chk("rr_seq", 128'(grant_port), 128'(seq[k % 3]));
            chk("no_bubble", 128'(ack_to_input_ports != 0), 1);
        end

        drain();
        mode = 1;
        pkt[4] = newpkt(1);
        prev_nz = 0;
        repeat (12) begin
            step();
            chk("consec_ack", 128'(prev_nz && ack_to_input_ports != 0), 0);
            prev_nz = ack_to_input_ports != 0;
        end

        drain();
        mode = 2;
        pkt[1] = newpkt(1); pkt[2] = newpkt(1);
        saved = pkt[1];
        step();
        chk("stall_first", 128'(grant_port), 3);
        stream_out_ready = 1'b0;
        repeat (5) begin
            step();
            chk("stall_grant", 128'(grant_port), 3);
            chk("stall_data", 128'(stream_out), 128'(saved));
            chk("stall_ack", 128'(ack_to_input_ports), 0);
        end
        stream_out_ready = 1'b1;
        step();
        chk("after_stall", 128'(grant_port), 4);

        drain();
        pkt[3] = newpkt(1);
        stream_out_ready = 1'b0;
        repeat (3) step();
        #3;
        reset = 1'b0;
        #1;
        chk("async_stream", 128'(stream_out), 0);
        chk("async_grant", 128'(grant_port), 0);
        chk("async_ack", 128'(ack_to_input_ports), 0);
        model_reset();
        @(negedge clk_bft);
        reset = 1'b1;
        for (int i = 0; i < N; i++) pkt[i] = newpkt(1);
        stream_out_ready = 1'b1;
        step();
        chk("post_rst_prio", 128'(grant_port), 2);

        mode = 3;
        repeat (400) begin
            stream_out_ready = $urandom_range(0, 9) < 7;
            for (int i = 0; i < N; i++)
                if (!pkt[i][PB-1] && !pending[i] && $urandom_range(0, 9) < 3) pkt[i] = newpkt(1);
            step();
        end

`ifdef INPUT_PACKET_ARBITER_STATS_EN
        drain();
        pkt[0] = newpkt(1);
        stream_out_ready = 1'b0;
        repeat (70000) step();
        chk("stall_sat", 128'(stall_count), 128'(16'hFFFF));
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        chk("stall_rst", 128'(stall_count), 0);
        @(negedge clk_bft);
        reset = 1'b1;
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
